// File: rtl/eth_rt_send_arbiter_pkg.sv
// Shared constants for the real-time Ethernet send arbiter: FSM encoding,
// debug register tag and signature, and a saturating counter helper.
package eth_rt_send_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_START  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_GAP    = 2'd3
   } arb_state_t;

   localparam logic [3:0]  DBG_TAG       = 4'hb;
   localparam logic [31:0] DBG_SIGNATURE = 32'h4152_4244;  // "ARBD"

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/eth_rt_send_arbiter_if.sv
// Request/grant bundle between the send sources, the arbiter and the Tx engine.
// The slave side is the arbiter; the master side is the requesters plus engine.
interface eth_rt_send_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic               tx_start;
   logic [1:0]         tx_src;
   logic               tx_active;

   modport master (
      output req,
      output tx_active,
      input  gnt,
      input  tx_start,
      input  tx_src
   );

   modport slave (
      input  req,
      input  tx_active,
      output gnt,
      output tx_start,
      output tx_src
   );
endinterface

// File: rtl/eth_rt_send_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// (with wrap) from the slot after the last winner.
module eth_rt_send_arbiter_rr_pick #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         last,
   output logic               valid,
   output logic [1:0]         winner
);

   logic [1:0] cand;

   // Walk from the farthest slot back to the nearest so the nearest match is written last.
   always_comb begin
      valid  = 1'b0;
      winner = 2'd0;
      cand   = 2'd0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = 2'((int'(last) + k) % NUM_REQ);
         if (req[cand]) begin
            valid  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/eth_rt_send_arbiter.sv
// Real-time Ethernet transmit arbiter: class priority plus round-robin grant,
// interpacket gap enforcement, start/frame watchdogs and debug registers.
module eth_rt_send_arbiter
   import eth_rt_send_arbiter_pkg::*;
#(
   parameter int         NUM_REQ          = 3,
   parameter logic [3:0] HI_PRI_MASK      = 4'b0010,
   parameter int         IPG_CYCLES       = 12,
   parameter int         START_TIMEOUT    = 8,
   parameter int         MAX_FRAME_CYCLES = 1600
) (
   input  logic                 clk,
   input  logic                 reset,
   eth_rt_send_arbiter_if.slave bus,
   input  logic                 clearErrors,
   output logic                 arb_error,
   input  logic [15:0]          reg_raddr,
   output logic [31:0]          reg_rdata
);

   localparam logic [NUM_REQ-1:0] HI_MASK = HI_PRI_MASK[NUM_REQ-1:0];
   localparam logic [15:0] START_LAST = 16'(START_TIMEOUT - 1);
   localparam logic [15:0] FRAME_LAST = 16'(MAX_FRAME_CYCLES - 1);
   localparam logic [15:0] GAP_LOAD   = 16'(IPG_CYCLES - 1);

   arb_state_t         state;
   logic [NUM_REQ-1:0] gnt_reg;
   logic               tx_start_reg;
   logic [1:0]         tx_src_reg;
   logic [1:0]         rr_last;
   logic [7:0]         grant_cnt [NUM_REQ];
   logic [15:0]        frame_cnt;
   logic [15:0]        start_cnt;
   logic [15:0]        gap_cnt;
   logic [15:0]        start_err_cnt;
   logic [15:0]        frame_err_cnt;
   logic               start_err;
   logic               frame_err;

   logic               hi_valid;
   logic [1:0]         hi_winner;
   logic               all_valid;
   logic [1:0]         all_winner;
   logic [1:0]         winner;

   eth_rt_send_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_hi (
      .req    (bus.req & HI_MASK),
      .last   (rr_last),
      .valid  (hi_valid),
      .winner (hi_winner)
   );

   eth_rt_send_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_all (
      .req    (bus.req),
      .last   (rr_last),
      .valid  (all_valid),
      .winner (all_winner)
   );

   // High class only shadows the full picker when one of its members is asking.
   assign winner = hi_valid ? hi_winner : all_winner;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         gnt_reg       <= '0;
         tx_start_reg  <= 1'b0;
         tx_src_reg    <= 2'd0;
         rr_last       <= 2'(NUM_REQ - 1);
         frame_cnt     <= '0;
         start_cnt     <= '0;
         gap_cnt       <= '0;
         start_err_cnt <= '0;
         frame_err_cnt <= '0;
         start_err     <= 1'b0;
         frame_err     <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i] <= '0;
         end
      end else begin
         // Clear is written first so an error set later in this block overrides it.
         if (clearErrors) begin
            start_err <= 1'b0;
            frame_err <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (all_valid && !bus.tx_active) begin
                  gnt_reg           <= NUM_REQ'(1) << winner;
                  tx_src_reg        <= winner;
                  tx_start_reg      <= 1'b1;
                  rr_last           <= winner;
                  grant_cnt[winner] <= grant_cnt[winner] + 8'd1;
                  start_cnt         <= '0;
                  state             <= ST_START;
               end
            end

            ST_START: begin
               if (start_cnt == START_LAST) begin
                  start_err     <= 1'b1;
                  start_err_cnt <= sat_inc16(start_err_cnt);
                  gnt_reg       <= '0;
                  tx_start_reg  <= 1'b0;
                  gap_cnt       <= GAP_LOAD;
                  state         <= ST_GAP;
               end else if (bus.tx_active) begin
                  tx_start_reg <= 1'b0;
                  frame_cnt    <= '0;
                  state        <= ST_ACTIVE;
               end else begin
                  start_cnt <= start_cnt + 16'd1;
               end
            end

            ST_ACTIVE: begin
               if (!bus.tx_active) begin
                  gnt_reg <= '0;
                  gap_cnt <= GAP_LOAD;
                  state   <= ST_GAP;
               end else if (frame_cnt == FRAME_LAST) begin
                  // Engine keeps running; GAP holds until it finally goes idle.
                  frame_err     <= 1'b1;
                  frame_err_cnt <= sat_inc16(frame_err_cnt);
                  gnt_reg       <= '0;
                  gap_cnt       <= GAP_LOAD;
                  state         <= ST_GAP;
               end else begin
                  frame_cnt <= sat_inc16(frame_cnt);
               end
            end

            ST_GAP: begin
               if (!bus.tx_active) begin
                  if (gap_cnt == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     gap_cnt <= gap_cnt - 16'd1;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt      = gnt_reg;
   assign bus.tx_start = tx_start_reg;
   assign bus.tx_src   = tx_src_reg;
   assign arb_error    = start_err | frame_err;

   logic [31:0] word1;
   logic [31:0] word2;
   logic [31:0] word3;

   assign word1 = {state, tx_src_reg, 2'b00, start_err, frame_err, 8'(gnt_reg), frame_cnt};
   assign word3 = {start_err_cnt, frame_err_cnt};

   for (genvar gi = 0; gi < 4; gi++) begin : g_word2
      if (gi < NUM_REQ) begin : g_used
         assign word2[gi*8 +: 8] = grant_cnt[gi];
      end else begin : g_unused
         assign word2[gi*8 +: 8] = 8'd0;
      end
   end

   always_comb begin
      reg_rdata = '0;
      if (reg_raddr[7:4] == DBG_TAG) begin
         case (reg_raddr[1:0])
            2'd0:    reg_rdata = DBG_SIGNATURE;
            2'd1:    reg_rdata = word1;
            2'd2:    reg_rdata = word2;
            default: reg_rdata = word3;
         endcase
      end
   end

   logic unused_addr;
   assign unused_addr = ^{reg_raddr[15:8], reg_raddr[3:2]};

endmodule

// File: tb/tb_eth_rt_send_arbiter.sv
// Bench for eth_rt_send_arbiter: directed scenarios plus random frames, with a
// grant scoreboard fed by a priority/round-robin reference model.
module tb_eth_rt_send_arbiter;

   localparam int NR = 3;
   localparam logic [NR-1:0] HI = 3'b010;

   logic        clk = 1'b0;
   logic        reset;
   logic        clearErrors;
   logic        arb_error;
   logic [15:0] reg_raddr;
   logic [31:0] reg_rdata;

   eth_rt_send_arbiter_if #(.NUM_REQ(NR)) bus ();

   eth_rt_send_arbiter #(.NUM_REQ(NR)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .clearErrors (clearErrors),
      .arb_error   (arb_error),
      .reg_raddr   (reg_raddr),
      .reg_rdata   (reg_rdata)
   );

   always #5 clk = ~clk;

   int checks;
   int errors;
   int exp_q[$];
   int m_last;
   int m_cnt[NR];
   int last_w;

   int          mon_cyc;
   int          fall_cyc;
   int          grant_no;
   int          mon_w;
   bit          has_fall;
   logic        prev_act;
   logic [NR-1:0] prev_gnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic read_reg(input logic [15:0] a, output logic [31:0] d);
      reg_raddr = a;
      #1;
      d = reg_rdata;
   endtask

   // Reference rule: restrict to the high class if any member asks, then take the
   // first asking source after the previous winner in cyclic order.
   function automatic int model_pick(input logic [NR-1:0] r);
      logic [NR-1:0] c;
      int idx;
      c = ((r & HI) != '0) ? (r & HI) : r;
      for (int k = 1; k <= NR; k++) begin
         idx = (m_last + k) % NR;
         if (((c >> idx) & NR'(1)) != '0) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_last = NR - 1;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
   endtask

   task automatic issue(input logic [NR-1:0] r);
      int w;
      w = model_pick(r);
      exp_q.push_back(w);
      m_last = w;
      m_cnt[w] = (m_cnt[w] + 1) % 256;
      last_w = w;
      bus.req = r;
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (bus.tx_start) ok = 1'b1;
         else step(1);
      end
      check("grant_seen", 32'(ok), 32'd1);
   endtask

   task automatic finish_frame(input int rise, input int len);
      step(rise);
      bus.tx_active = 1'b1;
      step(len);
      check("gnt_held", 32'(bus.gnt), 32'(1) << last_w);
      bus.tx_active = 1'b0;
      step(1);
      check("gnt_drop", 32'(bus.gnt), 32'd0);
   endtask

   task automatic run_frame(input logic [NR-1:0] r, input int rise, input int len);
      bit ok;
      issue(r);
      wait_grant(ok);
      if (!ok) return;
      bus.req = '0;
      finish_frame(rise, len);
   endtask

   // Monitor: every rising grant pops one expectation and checks the gap.
   initial begin
      mon_cyc  = 0;
      fall_cyc = 0;
      grant_no = 0;
      has_fall = 1'b0;
      prev_act = 1'b0;
      prev_gnt = '0;
      forever begin
         @(posedge clk);
         #2;
         mon_cyc++;
         if (!reset) begin
            has_fall = 1'b0;
            prev_act = 1'b0;
            prev_gnt = '0;
         end else begin
            if (prev_act && !bus.tx_active) begin
               has_fall = 1'b1;
               fall_cyc = mon_cyc;
            end
            if (prev_gnt == '0 && bus.gnt != '0) begin
               grant_no++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_grant: got gnt=%b, required no grant", bus.gnt);
               end else begin
                  mon_w = exp_q.pop_front();
                  $display("grant %0d: src=%0d gnt=%b expected src=%0d", grant_no, bus.tx_src, bus.gnt, mon_w);
                  check("grant_onehot", 32'(bus.gnt), 32'(1) << mon_w);
                  check("grant_src", 32'(bus.tx_src), 32'(mon_w));
                  check("grant_start", 32'(bus.tx_start), 32'd1);
               end
               if (has_fall) check("ipg_min_13", 32'((mon_cyc - fall_cyc) >= 13), 32'd1);
            end
            prev_act = bus.tx_active;
            prev_gnt = bus.gnt;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required normal end");
      $fatal(1, "time limit");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] e;
      bit ok;
      checks = 0;
      errors = 0;
      model_reset();
      reset = 1'b0;
      clearErrors = 1'b0;
      reg_raddr = '0;
      bus.req = '0;
      bus.tx_active = 1'b0;

      // Reset state
      step(3);
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_tx_start", 32'(bus.tx_start), 32'd0);
      check("rst_tx_src", 32'(bus.tx_src), 32'd0);
      check("rst_arb_error", 32'(arb_error), 32'd0);
      reset = 1'b1;
      step(1);
      read_reg(16'h00b0, d); check("dbg_sig", d, 32'h4152_4244);
      read_reg(16'h00b1, d); check("dbg_word1_rst", d, 32'd0);
      read_reg(16'h00b2, d); check("dbg_word2_rst", d, 32'd0);
      read_reg(16'h00b3, d); check("dbg_word3_rst", d, 32'd0);
      read_reg(16'h00c0, d); check("dbg_other_tag", d, 32'd0);

      // Single frame from source 0 with detailed timing
      step(1);
      issue(3'b001);
      check("lat_before_edge", 32'(bus.gnt), 32'd0);
      step(1);
      check("lat_gnt", 32'(bus.gnt), 32'h1);
      check("lat_tx_start", 32'(bus.tx_start), 32'd1);
      bus.req = '0;
      step(2);
      check("start_held", 32'(bus.tx_start), 32'd1);
      bus.tx_active = 1'b1;
      step(1);
      check("start_clear", 32'(bus.tx_start), 32'd0);
      check("gnt_kept_no_req", 32'(bus.gnt), 32'h1);
      step(99);
      read_reg(16'h00b1, d); check("dbg_word1_active", d, 32'h8001_0063);
      bus.tx_active = 1'b0;
      step(1);
      check("gnt_drop_edge", 32'(bus.gnt), 32'd0);

      // High class wins while it asks, then plain round-robin
      for (int i = 0; i < 3; i++) run_frame(3'b111, 2, 20);
      for (int i = 0; i < 4; i++) run_frame(3'b101, 2, 20);

      // Random frames
      for (int i = 0; i < 20; i++)
         run_frame(NR'($urandom_range(1, 7)), $urandom_range(1, 6), $urandom_range(3, 40));
      e = '0;
      for (int i = 0; i < NR; i++) e[i*8 +: 8] = 8'(m_cnt[i]);
      read_reg(16'h00b2, d); check("dbg_grant_cnt", d, e);

      // Start timeout
      issue(3'b100);
      wait_grant(ok);
      bus.req = '0;
      step(7);
      check("to_gnt_before", 32'(bus.gnt), 32'(1) << last_w);
      check("to_err_before", 32'(arb_error), 32'd0);
      step(1);
      check("to_gnt_after", 32'(bus.gnt), 32'd0);
      check("to_start_after", 32'(bus.tx_start), 32'd0);
      check("to_arb_error", 32'(arb_error), 32'd1);
      read_reg(16'h00b1, d); check("to_word1_hi", 32'(d[31:24]), 32'hE2);

      // Second timeout coincides with clearErrors: set wins
      issue(3'b100);
      wait_grant(ok);
      bus.req = '0;
      step(7);
      clearErrors = 1'b1;
      step(1);
      clearErrors = 1'b0;
      check("set_beats_clear", 32'(arb_error), 32'd1);
      read_reg(16'h00b3, d); check("start_err_cnt", d, {16'd2, 16'd0});
      step(1);
      clearErrors = 1'b1;
      step(1);
      clearErrors = 1'b0;
      check("clear_errors", 32'(arb_error), 32'd0);

      // Overlong frame
      issue(3'b001);
      wait_grant(ok);
      bus.req = '0;
      step(1);
      bus.tx_active = 1'b1;
      step(1600);
      check("fr_gnt_before", 32'(bus.gnt), 32'h1);
      check("fr_err_before", 32'(arb_error), 32'd0);
      step(1);
      check("fr_gnt_after", 32'(bus.gnt), 32'd0);
      check("fr_arb_error", 32'(arb_error), 32'd1);
      read_reg(16'h00b1, d); check("fr_word1_hi", 32'(d[31:24]), 32'hC1);
      step(98);
      issue(3'b010);
      step(1);
      check("fr_no_start_busy", 32'(bus.tx_start), 32'd0);
      bus.tx_active = 1'b0;
      step(5);
      check("fr_no_start_gap", 32'(bus.tx_start), 32'd0);
      wait_grant(ok);
      bus.req = '0;
      finish_frame(2, 10);
      read_reg(16'h00b3, d); check("err_counts", d, {16'd2, 16'd1});

      // Asynchronous reset mid-frame
      issue(3'b100);
      wait_grant(ok);
      bus.req = '0;
      step(2);
      bus.tx_active = 1'b1;
      step(10);
      reset = 1'b0;
      #1;
      check("arst_gnt", 32'(bus.gnt), 32'd0);
      check("arst_tx_start", 32'(bus.tx_start), 32'd0);
      check("arst_arb_error", 32'(arb_error), 32'd0);
      bus.tx_active = 1'b0;
      model_reset();
      read_reg(16'h00b0, d); check("arst_sig", d, 32'h4152_4244);
      read_reg(16'h00b1, d); check("arst_word1", d, 32'd0);
      read_reg(16'h00b2, d); check("arst_word2", d, 32'd0);
      read_reg(16'h00b3, d); check("arst_word3", d, 32'd0);
      step(2);
      reset = 1'b1;
      step(1);
      run_frame(3'b101, 2, 10);
      run_frame(3'b101, 2, 10);
      step(3);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
